// File: rtl/uart_rx_fifo_pkg.sv
// uart_rx_fifo_pkg: shared definitions for the UART receive path stages.
// Holds the capture FSM state encodings and the FIFO default geometry.
package uart_rx_fifo_pkg;

    localparam int UART_DATA_WIDTH = 8;
    localparam int UART_DEPTH_LOG2 = 4;

    typedef enum logic [1:0] {
        sIdle = 2'b00,
        sAck  = 2'b01,
        sWait = 2'b10
    } cap_state_e;

    localparam logic [7:0] DROP_MAX = 8'hFF;

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// uart_rx_fifo_mem: 2**AW x DW register file, synchronous write, async read.
// Ports: clk, we_i/waddr_i/wdata_i write port, raddr_i/rdata_o read port.
module uart_rx_fifo_mem #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: catches bytes from uart_receive (ready level / reset_ready ack)
// and buffers them in a first-word-fall-through FIFO for the consumer.
// Ports: clk, reset (sync, active-low); rx_data/rx_ready in, rx_reset_ready out;
//   rd_en in, rd_data/empty/full/count out; overflow out, clear_overflow in.
// Option UART_RX_FIFO_STATS_EN: adds drop_count[7:0] (saturating drop counter).
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int DEPTH_LOG2 = UART_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_ready,
    output logic                  rx_reset_ready,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    input  logic                  clear_overflow
`ifdef UART_RX_FIFO_STATS_EN
   ,output logic [7:0]            drop_count
`endif
);

    localparam int DEPTH = 2**DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] CNT_FULL = DEPTH[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0] CNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    cap_state_e state_q, state_d;

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  ovf_q, ovf_d;

    logic                  capture;
    logic                  push;
    logic                  pop;
    logic                  drop;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Capture FSM: sWait holds until rx_ready falls so a byte whose ready
    // level outlives the ack is not captured twice.
    always_comb begin
        state_d        = state_q;
        capture        = 1'b0;
        rx_reset_ready = 1'b0;
        unique case (state_q)
            sIdle: begin
                if (rx_ready) begin
                    capture = 1'b1;
                    state_d = sAck;
                end
            end
            sAck: begin
                rx_reset_ready = 1'b1;
                state_d        = sWait;
            end
            sWait: begin
                if (!rx_ready) begin
                    state_d = sIdle;
                end
            end
            default: state_d = sIdle;
        endcase
    end

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_FULL);
    assign count = count_q;

    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign pop  = rd_en && !empty;
    assign push = capture && (!full || pop);
    assign drop = capture && full && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end
        // Drop wins over clear so no lost byte goes unreported.
        if (clear_overflow) begin
            ovf_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= sIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    assign overflow = ovf_q;

    uart_rx_fifo_mem #(
        .DW (DATA_WIDTH),
        .AW (DEPTH_LOG2)
    ) u_mem (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (rx_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (mem_rdata)
    );

    // Storage is not reset; masking keeps rd_data at zero while empty.
    assign rd_data = empty ? '0 : mem_rdata;

`ifdef UART_RX_FIFO_STATS_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (clear_overflow) begin
            drop_cnt_d = '0;
        end
        if (drop && drop_cnt_d != DROP_MAX) begin
            drop_cnt_d = drop_cnt_d + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scoreboard bench for uart_rx_fifo.
// A queue model tracks accepted bytes; a negedge monitor compares outputs.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_reset_ready;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overflow;
    logic       clear_overflow;
`ifdef UART_RX_FIFO_STATS_EN
    logic [7:0] drop_count;
`endif

    logic rd_force = 1'b0;
    logic rd_rand = 1'b0;
    bit   rand_on = 1'b0;
    assign rd_en = rd_force || rd_rand;

    always #5 clk = ~clk;

    uart_rx_fifo dut (
        .clk            (clk),
        .reset          (reset),
        .rx_data        (rx_data),
        .rx_ready       (rx_ready),
        .rx_reset_ready (rx_reset_ready),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .empty          (empty),
        .full           (full),
        .count          (count),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
`ifdef UART_RX_FIFO_STATS_EN
       ,.drop_count     (drop_count)
`endif
    );

    int tests = 0;
    int errors = 0;

    logic [7:0] sb[$];
    int  raise_cnt = 0;
    int  cap_cnt = 0;
    bit  exp_ack = 1'b0;
    bit  exp_ovf = 1'b0;
    int  exp_drops = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a byte offered while the receiver is idle is kept if
    // fewer than DEPTH bytes remain after this edge's pop, else it is lost.
    always @(posedge clk) begin
        bit cap;
        bit drp;
        if (!reset) begin
            sb.delete();
            exp_ack   = 1'b0;
            exp_ovf   = 1'b0;
            exp_drops = 0;
            cap_cnt   = raise_cnt;
        end else begin
            cap = rx_ready && (raise_cnt != cap_cnt);
            drp = 1'b0;
            if (cap) begin
                cap_cnt++;
                if (sb.size() < DEPTH) sb.push_back(rx_data);
                else drp = 1'b1;
            end
            exp_ack = cap;
            exp_ovf = (exp_ovf && !clear_overflow) || drp;
            if (clear_overflow) exp_drops = 0;
            if (drp && exp_drops < 255) exp_drops++;
        end
    end

    // Monitor: compares the presented state and pops on accepted reads.
    always @(negedge clk) begin
        if (!reset) begin
            check("rst_ack", rx_reset_ready, 0);
            check("rst_empty", empty, 1);
            check("rst_count", count, 0);
            check("rst_ovf", overflow, 0);
        end else begin
            check("ack", rx_reset_ready, exp_ack);
            check("count", count, sb.size());
            check("empty", empty, sb.size() == 0);
            check("full", full, sb.size() == DEPTH);
            check("overflow", overflow, exp_ovf);
`ifdef UART_RX_FIFO_STATS_EN
            check("drop_count", drop_count, exp_drops);
`endif
            if (sb.size() == 0) begin
                check("rd_data_empty", rd_data, 0);
            end else if (rd_en) begin
                check("rd_data_pop", rd_data, sb.pop_front());
            end else begin
                check("rd_data_head", rd_data, sb[0]);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            rd_rand = rand_on ? ($urandom_range(0, 9) < 4) : 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] b, input int hold, input bit pop_cap);
        bit got;
        rx_data  = b;
        rx_ready = 1'b1;
        raise_cnt++;
        rd_force = pop_cap;
        tick();
        rd_force = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (rx_reset_ready) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        check("ack_seen", got, 1);
        repeat (hold) tick();
        rx_ready = 1'b0;
        repeat (2) tick();
    endtask

    task automatic drain();
        rd_force = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0) break;
            tick();
        end
        rd_force = 1'b0;
        tick();
        check("drained", sb.size(), 0);
    endtask

    task automatic clear_ovf();
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
    endtask

    initial begin
        reset          = 1'b0;
        rx_data        = 8'h00;
        rx_ready       = 1'b1;
        clear_overflow = 1'b0;
        repeat (2) tick();
        rx_ready = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        send(8'hA5, 0, 1'b0);
        tick();
        send(8'h3C, 20, 1'b0);
        drain();

        for (int i = 0; i < DEPTH; i++) send(8'(i), 0, 1'b0);
        send(8'hFF, 0, 1'b0);
        drain();
        clear_ovf();

        for (int i = 0; i < DEPTH; i++) send(8'(i + 16), 0, 1'b0);
        send(8'h55, 0, 1'b1);
        drain();

        for (int i = 0; i < DEPTH; i++) send(8'($urandom), 0, 1'b0);
`ifdef UART_RX_FIFO_STATS_EN
        for (int i = 0; i < 300; i++) send(8'($urandom), 0, 1'b0);
`else
        for (int i = 0; i < 5; i++) send(8'($urandom), 0, 1'b0);
`endif
        clear_ovf();
        send(8'h77, 0, 1'b0);
        clear_overflow = 1'b1;
        send(8'h78, 0, 1'b0);
        clear_overflow = 1'b0;
        drain();
        clear_ovf();

        rand_on = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) == 0) clear_ovf();
            send(8'($urandom), $urandom_range(0, 3), 1'b0);
        end
        rand_on = 1'b0;
        tick();
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
